// File: rtl/lb_pkg.sv
// -----------------------------------------------------------------------------
// lb_pkg
// Shared definitions for the line-buffer scheduler.
//   lb_state_e : controller states (IDLE, LOAD, PUSH, FLUSH, DONE)
//   LB_NO_PTR  : slot pointer value meaning "no array slot is written"
// -----------------------------------------------------------------------------
package lb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PUSH,
      ST_FLUSH,
      ST_DONE
   } lb_state_e;

   localparam logic [2:0] LB_NO_PTR = 3'b111;

endpackage

// File: rtl/lb_wrap_ctr.sv
// -----------------------------------------------------------------------------
// lb_wrap_ctr
// Modulo-MOD counter with synchronous load and count enable.
// Ports:
//   clk      : rising-edge clock
//   rstn     : synchronous active-low reset, clears the count
//   load     : load load_val (has priority over en)
//   load_val : value loaded when load is high
//   en       : advance by one, wrapping MOD-1 -> 0
//   cnt      : current count
// -----------------------------------------------------------------------------
module lb_wrap_ctr
   import lb_pkg::*;
#(
   parameter int MOD = 5,
   parameter int W   = 3
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // NOTE: every combinational output gets its hold value first, so no path
   // through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en) begin
         cnt_d = (cnt_q == W'(MOD - 1)) ? '0 : cnt_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/line_buffer_sched.sv
// -----------------------------------------------------------------------------
// line_buffer_sched
// Controller for a K-column line-buffer array. Accepts upstream columns,
// inserts PAD zero columns at each row edge, tells the array which slot to
// write, and flags when the array output holds a complete window.
// Ports:
//   clk, rstn           : clock, synchronous active-low reset
//   start               : frame start (ignored unless idle)
//   img_width/height    : frame dimensions, sampled on start
//   col_valid/col_ready : upstream column handshake
//   win_ready           : downstream can take a window; low stalls everything
//   col_ptr             : slot written this cycle (LB_NO_PTR when no push)
//   init_col_ptr        : fill level for this push (LB_NO_PTR when no push)
//   left_pad_mask       : per-slot zero mask, valid in the push cycle
//   right_pad_mask      : per-position zero mask aligned with the window
//   dummy_col           : this push carries no upstream data (pixels are zero)
//   win_valid           : array output holds a new window this cycle
//   busy, done          : frame in progress / one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module line_buffer_sched
   import lb_pkg::*;
#(
   parameter int KER_SIZE = 5,
   parameter int AW       = 8,
   parameter int PAD      = 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic [AW-1:0]       img_width,
   input  logic [AW-1:0]       img_height,
   input  logic                col_valid,
   output logic                col_ready,
   input  logic                win_ready,
   output logic [2:0]          col_ptr,
   output logic [2:0]          init_col_ptr,
   output logic [KER_SIZE-1:0] left_pad_mask,
   output logic [KER_SIZE-1:0] right_pad_mask,
   output logic                dummy_col,
   output logic                win_valid,
   output logic                busy,
   output logic                done
);

   lb_state_e           state_q, state_d;
   logic [AW-1:0]       width_q, width_d;
   logic [AW-1:0]       height_q, height_d;
   logic [AW-1:0]       row_q, row_d;
   logic [AW-1:0]       col_cnt_q, col_cnt_d;
   logic [AW:0]         win_idx_q, win_idx_d;
   logic [2:0]          fill_q, fill_d;
   logic [2:0]          dummy_cnt_q, dummy_cnt_d;
   logic [KER_SIZE-1:0] right_mask_q, right_mask_d;
   logic                win_valid_q, win_valid_d;

   logic                push;
   logic                dummy;
   logic                row_end;
   logic                ptr_load;
   logic [2:0]          ptr;
   logic [KER_SIZE-1:0] dummy_mask;

   // Write slot pointer: starts each row at PAD so the left pad slots are
   // already "filled" by the zero mask.
   lb_wrap_ctr #(
      .MOD (KER_SIZE),
      .W   (3)
   ) u_ptr (
      .clk      (clk),
      .rstn     (rstn),
      .load     (ptr_load),
      .load_val (3'(PAD)),
      .en       (push),
      .cnt      (ptr)
   );

   always_comb begin
      state_d      = state_q;
      width_d      = width_q;
      height_d     = height_q;
      row_d        = row_q;
      col_cnt_d    = col_cnt_q;
      win_idx_d    = win_idx_q;
      fill_d       = fill_q;
      dummy_cnt_d  = dummy_cnt_q;
      right_mask_d = right_mask_q;
      win_valid_d  = 1'b0;
      push         = 1'b0;
      dummy        = 1'b0;
      row_end      = 1'b0;
      ptr_load     = 1'b0;

      // Dummy push d = dummy_cnt_q+1 zeroes the top d window positions.
      for (int i = 0; i < KER_SIZE; i++) begin
         dummy_mask[i] = (i >= KER_SIZE - (int'(dummy_cnt_q) + 1));
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               width_d  = img_width;
               height_d = img_height;
               row_d    = '0;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            ptr_load    = 1'b1;
            fill_d      = 3'(PAD);
            win_idx_d   = '0;
            dummy_cnt_d = '0;
            col_cnt_d   = '0;
            state_d     = ST_PUSH;
         end
         ST_PUSH: begin
            if (col_valid && win_ready) begin
               push      = 1'b1;
               col_cnt_d = col_cnt_q + 1'b1;
               if (col_cnt_q == width_q - 1'b1) begin
                  if (PAD == 0) row_end = 1'b1;
                  else          state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            if (win_ready) begin
               push        = 1'b1;
               dummy       = 1'b1;
               dummy_cnt_d = dummy_cnt_q + 3'd1;
               if (int'(dummy_cnt_q) + 1 == PAD) row_end = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (row_end) begin
         if (row_q == height_q - 1'b1) begin
            state_d = ST_DONE;
         end else begin
            row_d   = row_q + 1'b1;
            state_d = ST_LOAD;
         end
      end

      // Once the array is full every further push completes a window.
      if (push) begin
         if (fill_q == 3'(KER_SIZE - 1)) begin
            win_valid_d = 1'b1;
            win_idx_d   = win_idx_q + 1'b1;
         end else begin
            fill_d = fill_q + 3'd1;
         end
         right_mask_d = dummy ? dummy_mask : '0;
      end

      for (int s = 0; s < KER_SIZE; s++) begin
         left_pad_mask[s] = push && (int'(win_idx_q) <= s) && (s < PAD);
      end
   end

   // Reset clears every register, so an abandoned frame leaves no trace.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         width_q      <= '0;
         height_q     <= '0;
         row_q        <= '0;
         col_cnt_q    <= '0;
         win_idx_q    <= '0;
         fill_q       <= '0;
         dummy_cnt_q  <= '0;
         right_mask_q <= '0;
         win_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         width_q      <= width_d;
         height_q     <= height_d;
         row_q        <= row_d;
         col_cnt_q    <= col_cnt_d;
         win_idx_q    <= win_idx_d;
         fill_q       <= fill_d;
         dummy_cnt_q  <= dummy_cnt_d;
         right_mask_q <= right_mask_d;
         win_valid_q  <= win_valid_d;
      end
   end

   assign col_ready      = (state_q == ST_PUSH) && win_ready;
   assign col_ptr        = push ? ptr : LB_NO_PTR;
   assign init_col_ptr   = push ? fill_q : LB_NO_PTR;
   assign dummy_col      = dummy;
   assign right_pad_mask = right_mask_q;
   assign win_valid      = win_valid_q;
   assign busy           = (state_q == ST_LOAD) || (state_q == ST_PUSH) ||
                           (state_q == ST_FLUSH);
   assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_line_buffer_sched.sv
// -----------------------------------------------------------------------------
// tb_line_buffer_sched
// Scoreboard bench for line_buffer_sched (K=5, PAD=1). Each frame enqueues
// its expected push and window sequence; a negedge monitor pops and compares
// whenever the DUT pushes a column or raises win_valid.
// -----------------------------------------------------------------------------
module tb_line_buffer_sched;
   import lb_pkg::*;

   localparam int K  = 5;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start;
   logic [AW-1:0] img_width;
   logic [AW-1:0] img_height;
   logic          col_valid;
   logic          col_ready;
   logic          win_ready;
   logic [2:0]    col_ptr;
   logic [2:0]    init_col_ptr;
   logic [K-1:0]  left_pad_mask;
   logic [K-1:0]  right_pad_mask;
   logic          dummy_col;
   logic          win_valid;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   line_buffer_sched dut (
      .clk            (clk),
      .rstn           (rstn),
      .start          (start),
      .img_width      (img_width),
      .img_height     (img_height),
      .col_valid      (col_valid),
      .col_ready      (col_ready),
      .win_ready      (win_ready),
      .col_ptr        (col_ptr),
      .init_col_ptr   (init_col_ptr),
      .left_pad_mask  (left_pad_mask),
      .right_pad_mask (right_pad_mask),
      .dummy_col      (dummy_col),
      .win_valid      (win_valid),
      .busy           (busy),
      .done           (done)
   );

   typedef struct {
      int ptr;
      int init;
      int dummy;
      int left;
      int emit;
   } push_exp_t;

   push_exp_t push_q[$];
   int        win_q[$];
   push_exp_t pe;
   int        we;
   int        total    = 0;
   int        bad      = 0;
   int        done_cnt = 0;
   bit        pend_win = 1'b0;

   // Hand-derived sequences for K=5, PAD=1 (slot pointer and fill per push).
   int t8_ptr [9] = '{1, 2, 3, 4, 0, 1, 2, 3, 4};
   int t8_init[9] = '{1, 2, 3, 4, 4, 4, 4, 4, 4};
   int t5_ptr [6] = '{1, 2, 3, 4, 0, 1};
   int t5_init[6] = '{1, 2, 3, 4, 4, 4};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_col_ready"}, col_ready, 0);
      check({tag, "_col_ptr"}, col_ptr, 7);
      check({tag, "_init_col_ptr"}, init_col_ptr, 7);
      check({tag, "_left_mask"}, left_pad_mask, 0);
      check({tag, "_right_mask"}, right_pad_mask, 0);
      check({tag, "_dummy_col"}, dummy_col, 0);
      check({tag, "_win_valid"}, win_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   // Row of width w: w real pushes then one dummy; windows start at the 4th
   // push (fill reaches 4); only push 0..3 see win_idx 0 (left mask 00001);
   // only the last window (from the dummy push) carries right mask 10000.
   task automatic enqueue_frame(input int w, input int h);
      push_exp_t e;
      for (int r = 0; r < h; r++) begin
         for (int n = 0; n <= w; n++) begin
            e.ptr   = (w == 8) ? t8_ptr[n]  : t5_ptr[n];
            e.init  = (w == 8) ? t8_init[n] : t5_init[n];
            e.dummy = (n == w) ? 1 : 0;
            e.left  = (n < 4) ? 1 : 0;
            e.emit  = (n >= 3) ? 1 : 0;
            push_q.push_back(e);
         end
         for (int j = 0; j < w - 2; j++) begin
            win_q.push_back((j == w - 3) ? 16 : 0);
         end
      end
   endtask

   // Monitor: compare each push and each window against the scoreboard.
   always @(negedge clk) begin
      if (!rstn) begin
         pend_win = 1'b0;
      end else begin
         check("win_valid_timing", win_valid, pend_win);
         if (win_valid) begin
            if (win_q.size() == 0) begin
               check("win_unexpected", win_valid, 0);
            end else begin
               we = win_q.pop_front();
               check("right_pad_mask", right_pad_mask, we);
            end
         end
         pend_win = 1'b0;
         if (col_ptr != LB_NO_PTR) begin
            if (push_q.size() == 0) begin
               check("push_unexpected", col_ptr, LB_NO_PTR);
            end else begin
               pe = push_q.pop_front();
               check("col_ptr", col_ptr, pe.ptr);
               check("init_col_ptr", init_col_ptr, pe.init);
               check("dummy_col", dummy_col, pe.dummy);
               check("left_pad_mask", left_pad_mask, pe.left);
               pend_win = (pe.emit != 0);
            end
         end
         if (done) done_cnt++;
      end
   end

   // mode 0: free-running, 1: win_ready stall, 2: col_valid gaps plus a
   // start while busy, 3: reset during row 1.
   task automatic run_frame(input int w, input int h, input int mode);
      int d0;
      bit seen;
      bit aborted;
      d0      = done_cnt;
      seen    = 1'b0;
      aborted = 1'b0;
      enqueue_frame(w, h);
      @(posedge clk); #1;
      start      = 1'b1;
      img_width  = AW'(w);
      img_height = AW'(h);
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         start     = 1'b0;
         col_valid = 1'b1;
         win_ready = 1'b1;
         if (mode == 1 && k >= 4 && k <= 6) win_ready = 1'b0;
         if (mode == 2) begin
            col_valid = (k % 2 == 1);
            if (k == 5) begin
               start      = 1'b1;
               img_width  = AW'(5);
               img_height = AW'(1);
            end
         end
         if (mode == 3 && k == 14) rstn = 1'b0;
         @(negedge clk);
         if (mode == 1 && k >= 4 && k <= 6) begin
            check("stall_col_ready", col_ready, 0);
            check("stall_col_ptr", col_ptr, 7);
            check("stall_init_col_ptr", init_col_ptr, 7);
            check("stall_win_valid", win_valid, 0);
            check("stall_busy", busy, 1);
         end
         if (mode == 2 && k == 5) check("busy_in_push", busy, 1);
         if (mode == 3 && k == 14) begin
            @(posedge clk); #1;
            rstn = 1'b1;
            @(negedge clk);
            check_reset_values("midrst");
            aborted = 1'b1;
            break;
         end
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (aborted) begin
         repeat (5) @(negedge clk);
         check("no_done_after_abort", done_cnt - d0, 0);
         push_q.delete();
         win_q.delete();
      end else begin
         check("frame_done_seen", seen, 1);
         repeat (3) @(negedge clk);
         check("done_once", done_cnt - d0, 1);
         check("push_q_drained", push_q.size(), 0);
         check("win_q_drained", win_q.size(), 0);
         check("idle_busy", busy, 0);
      end
   endtask

   initial begin
      rstn       = 1'b0;
      start      = 1'b0;
      col_valid  = 1'b0;
      win_ready  = 1'b0;
      img_width  = '0;
      img_height = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("por");
      @(posedge clk); #1;
      rstn = 1'b1;

      run_frame(8, 2, 0);   // basic frame and edge masks
      run_frame(8, 2, 1);   // backpressure mid-row
      run_frame(8, 2, 2);   // input gaps, start while busy ignored
      run_frame(8, 2, 3);   // reset during row 1
      run_frame(8, 2, 0);   // full frame after reset
      run_frame(5, 1, 0);   // narrowest legal width

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
